// File: rtl/filtr_anc_mc.sv
// Multi-channel adaptive notch filter: NCH lattice channels time-shared over one
// registered multiplier, with run-time step size, freeze, coefficient clamp and overrun flag.
module filtr_anc_mc #(
    parameter int     DATA_W = 24,
    parameter int     COEF_W = 35,
    parameter int     NCH    = 4,
    parameter int     CH_W   = 2,
    parameter longint R      = longint'(1) <<< (COEF_W - 3),
    parameter longint R2     = longint'(1) <<< (COEF_W - 4),
    parameter longint A_INIT = 0,
    parameter longint A_MAX  = (longint'(1) <<< (COEF_W - 2)) * 15 / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CH_W-1:0]   ch_in,
    input  logic              sample_trig,
    input  logic              adapt_en,
    input  logic [5:0]        mu_shift,
    output logic              busy,
    output logic              filter_done,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   ch_out,
    output logic [COEF_W-1:0] coef_out,
    output logic              overrun
);
    localparam int SW    = DATA_W + 2;  // lattice state
    localparam int ASW   = DATA_W + 3;  // a*s1 term, |a| < 2
    localparam int XW    = ASW + 2;     // pre-saturation s
    localparam int EW    = DATA_W + 5;  // error e, never saturated internally
    localparam int OPA_W = (COEF_W > EW) ? COEF_W : EW;
    localparam int OPB_W = ASW;
    localparam int PW    = OPA_W + OPB_W;
    localparam int UW    = PW + 1;
    localparam int SH    = COEF_W - 2;

    localparam logic signed [COEF_W-1:0] R_C     = COEF_W'(R);
    localparam logic signed [COEF_W-1:0] R2_C    = COEF_W'(R2);
    localparam logic signed [COEF_W-1:0] AINIT_C = COEF_W'(A_INIT);
    localparam logic signed [COEF_W-1:0] AMAX_C  = COEF_W'(A_MAX);
    localparam logic signed [COEF_W-1:0] AMIN_C  = -AMAX_C;
    localparam logic signed [UW-1:0]     AMAX_U  = UW'(A_MAX);
    localparam logic signed [UW-1:0]     AMIN_U  = -AMAX_U;
    localparam logic signed [SW-1:0]     S_MAXV  = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0]     S_MINV  = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] D_MAXV  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MINV  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL_AS, MUL_RAS, MUL_R2S, SUM, MUL_UPD, WRITE} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      adapt_q, adapt_d, vld_q, vld_d;
    logic [5:0]                mu_q, mu_d;
    logic signed [SW-1:0]      s1w_q, s1w_d, s2w_q, s2w_d, s_q, s_d;
    logic signed [COEF_W-1:0]  aw_q, aw_d;
    logic signed [ASW-1:0]     as1_q, as1_d, ras_q, ras_d;
    logic signed [EW-1:0]      e_q, e_d;
    logic signed [PW-1:0]      prod_q, prod_d;
    logic                      busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic signed [DATA_W-1:0]  dout_q, dout_d;
    logic [CH_W-1:0]           chout_q, chout_d;
    logic signed [COEF_W-1:0]  coef_q, coef_d;

    logic signed [SW-1:0]      s1_m [NCH];
    logic signed [SW-1:0]      s2_m [NCH];
    logic signed [COEF_W-1:0]  a_m  [NCH];

    logic                      in_rng;
    logic signed [OPA_W-1:0]   opa;
    logic signed [OPB_W-1:0]   opb;
    logic signed [ASW-1:0]     r2s;
    logic signed [XW-1:0]      s_x;
    logic signed [PW-1:0]      upd;
    logic signed [UW-1:0]      diff;
    logic signed [COEF_W-1:0]  a_new;

    always_comb begin
        state_d = state_q;  x_d = x_q;  ch_d = ch_q;  adapt_d = adapt_q;  mu_d = mu_q;
        vld_d = vld_q;  s1w_d = s1w_q;  s2w_d = s2w_q;  aw_d = aw_q;
        as1_d = as1_q;  ras_d = ras_q;  s_d = s_q;  e_d = e_q;
        done_d = 1'b0;  dout_d = dout_q;  chout_d = chout_q;  coef_d = coef_q;
        ovr_d = ovr_q | (sample_trig & (state_q != IDLE));
        opa = '0;  opb = '0;  r2s = '0;  s_x = '0;  upd = '0;  diff = '0;  a_new = aw_q;
        in_rng = ({1'b0, ch_in} < (CH_W+1)'(NCH));

        case (state_q)
            IDLE: if (sample_trig) begin
                state_d = MUL_AS;
                x_d     = $signed(data_in);
                ch_d    = ch_in;
                adapt_d = adapt_en;
                mu_d    = mu_shift;
                vld_d   = in_rng;
                s1w_d   = in_rng ? s1_m[ch_in] : '0;
                s2w_d   = in_rng ? s2_m[ch_in] : '0;
                aw_d    = in_rng ? a_m[ch_in] : AINIT_C;
            end
            MUL_AS: begin
                opa = OPA_W'(aw_q);
                opb = OPB_W'(s1w_q);
                state_d = MUL_RAS;
            end
            MUL_RAS: begin
                as1_d = ASW'(prod_q >>> SH);
                opa = OPA_W'(R_C);
                opb = as1_d;
                state_d = MUL_R2S;
            end
            MUL_R2S: begin
                ras_d = ASW'(prod_q >>> SH);
                opa = OPA_W'(R2_C);
                opb = OPB_W'(s2w_q);
                state_d = SUM;
            end
            SUM: begin
                // The update product e*s1 is launched here so a_new is ready to register into WRITE.
                r2s = ASW'(prod_q >>> SH);
                s_x = XW'(x_q) - XW'(ras_q) - XW'(r2s);
                if (s_x > XW'(S_MAXV))      s_d = S_MAXV;
                else if (s_x < XW'(S_MINV)) s_d = S_MINV;
                else                        s_d = SW'(s_x);
                e_d = EW'(s_d) + EW'(as1_q) + EW'(s2w_q);
                opa = OPA_W'(e_d);
                opb = OPB_W'(s1w_q);
                state_d = MUL_UPD;
            end
            MUL_UPD: begin
                upd  = prod_q >>> mu_q;
                diff = UW'(aw_q) - UW'(upd);
                if (!vld_q)              a_new = AINIT_C;
                else if (!adapt_q)       a_new = aw_q;
                else if (diff > AMAX_U)  a_new = AMAX_C;
                else if (diff < AMIN_U)  a_new = AMIN_C;
                else                     a_new = COEF_W'(diff);
                if (e_q > EW'(D_MAXV))      dout_d = D_MAXV;
                else if (e_q < EW'(D_MINV)) dout_d = D_MINV;
                else                        dout_d = DATA_W'(e_q);
                chout_d = ch_q;
                coef_d  = a_new;
                done_d  = 1'b1;
                state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        prod_d = PW'(opa) * PW'(opb);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;  x_q <= '0;  ch_q <= '0;  adapt_q <= 1'b0;  mu_q <= '0;
            vld_q <= 1'b0;  s1w_q <= '0;  s2w_q <= '0;  aw_q <= AINIT_C;
            as1_q <= '0;  ras_q <= '0;  s_q <= '0;  e_q <= '0;  prod_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  ovr_q <= 1'b0;
            dout_q <= '0;  chout_q <= '0;  coef_q <= AINIT_C;
            for (int i = 0; i < NCH; i++) begin
                s1_m[i] <= '0;
                s2_m[i] <= '0;
                a_m[i]  <= AINIT_C;
            end
        end else begin
            state_q <= state_d;  x_q <= x_d;  ch_q <= ch_d;  adapt_q <= adapt_d;  mu_q <= mu_d;
            vld_q <= vld_d;  s1w_q <= s1w_d;  s2w_q <= s2w_d;  aw_q <= aw_d;
            as1_q <= as1_d;  ras_q <= ras_d;  s_q <= s_d;  e_q <= e_d;  prod_q <= prod_d;
            busy_q <= busy_d;  done_q <= done_d;  ovr_q <= ovr_d;
            dout_q <= dout_d;  chout_q <= chout_d;  coef_q <= coef_d;
            if (state_q == WRITE && vld_q) begin
                s2_m[ch_q] <= s1w_q;
                s1_m[ch_q] <= s_q;
                a_m[ch_q]  <= coef_q;
            end
        end
    end

    assign busy        = busy_q;
    assign filter_done = done_q;
    assign data_out    = dout_q;
    assign ch_out      = chout_q;
    assign coef_out    = coef_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_filtr_anc_mc.sv
// Scoreboard bench for filtr_anc_mc: the driver pushes model predictions, a monitor
// pops and compares on every filter_done.
module tb_filtr_anc_mc;
    localparam int     DATA_W = 24;
    localparam int     COEF_W = 35;
    localparam int     NCH    = 4;
    localparam int     CH_W   = 2;
    localparam longint R      = longint'(1) <<< (COEF_W - 3);
    localparam longint R2     = longint'(1) <<< (COEF_W - 4);
    localparam longint A_INIT = 0;
    localparam longint A_MAX  = (longint'(1) <<< (COEF_W - 2)) * 15 / 8;

    logic              clk = 1'b0, reset = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [CH_W-1:0]   ch_in = '0;
    logic              sample_trig = 1'b0, adapt_en = 1'b0;
    logic [5:0]        mu_shift = '0;
    logic              busy, filter_done, overrun;
    logic [DATA_W-1:0] data_out;
    logic [CH_W-1:0]   ch_out;
    logic [COEF_W-1:0] coef_out;

    always #5 clk = ~clk;

    filtr_anc_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NCH(NCH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .ch_in(ch_in),
        .sample_trig(sample_trig), .adapt_en(adapt_en), .mu_shift(mu_shift),
        .busy(busy), .filter_done(filter_done), .data_out(data_out), .ch_out(ch_out),
        .coef_out(coef_out), .overrun(overrun));

    int checks = 0, errors = 0, cyc = 0;
    bit sat_seen = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int ch; longint dout; longint coef; int acc;} exp_t;
    exp_t   sb[$];
    longint m_s1[NCH], m_s2[NCH], m_a[NCH];

    function automatic longint sat(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_a[i] = A_INIT;
        end
    endfunction

    function automatic void model_step(input int ch, input longint x, input bit ad, input int mu,
                                       output longint d, output longint c);
        longint s1, s2, a, as1, s, e, an;
        bit live = (ch < NCH);
        s1  = live ? m_s1[ch] : 0;
        s2  = live ? m_s2[ch] : 0;
        a   = live ? m_a[ch] : A_INIT;
        as1 = (a * s1) >>> (COEF_W - 2);
        s   = sat(x - ((R * as1) >>> (COEF_W - 2)) - ((R2 * s2) >>> (COEF_W - 2)), DATA_W + 2);
        e   = s + as1 + s2;
        d   = sat(e, DATA_W);
        an  = a;
        if (ad) begin
            an = a - ((e * s1) >>> mu);
            if (an > A_MAX) an = A_MAX;
            else if (an < -A_MAX) an = -A_MAX;
        end
        if (!live) an = A_INIT;
        c = an;
        if (live) begin
            m_s2[ch] = s1; m_s1[ch] = s; m_a[ch] = an;
        end
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every filter_done must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t   ex;
        longint c;
        if (filter_done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=done expected=none (t=%0t)", $time);
            end else begin
                ex = sb.pop_front();
                c  = $signed(coef_out);
                check("data_out", $signed(data_out), ex.dout);
                check("ch_out", longint'(ch_out), longint'(ex.ch));
                check("coef_out", c, ex.coef);
                check("latency", longint'(cyc + 1 - ex.acc), 6);
                check("coef_bound", longint'(c > A_MAX || c < -A_MAX), 0);
                if (c == A_MAX || c == -A_MAX) sat_seen = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int ch, input longint x, input bit ad, input int mu,
                        input bit has_exp, input longint exp_d);
        int n = 0;
        longint d, c;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check("idle_before_send", longint'(busy), 0);
        data_in = x[DATA_W-1:0]; ch_in = CH_W'(ch); adapt_en = ad; mu_shift = 6'(mu);
        sample_trig = 1'b1;
        model_step(ch, x, ad, mu, d, c);
        sb.push_back('{ch: ch, dout: (has_exp ? exp_d : d), coef: c, acc: cyc + 1});
        @(negedge clk);
        sample_trig = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
        check("drain_pending", longint'(sb.size()), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int     t3_ch  [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
    longint t3_x   [9] = '{1000, 0, 0, 0, 0, 0, 0, 0, 0};
    longint t3_exp [9] = '{1000, 0, 0, 0, 0, 0, 750, 0, 0};

    initial begin
        logic [DATA_W-1:0] rx;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(filter_done), 0);
        check("rst_overrun", longint'(overrun), 0);
        check("rst_data_out", $signed(data_out), 0);
        check("rst_ch_out", longint'(ch_out), 0);
        check("rst_coef_out", $signed(coef_out), A_INIT);
        for (int c = 0; c < NCH; c++) send(c, 0, 1'b0, 0, 1'b1, 0);
        drain();

        // Impulse on ch0, frozen coefficient.
        do_reset();
        send(0, 1000, 1'b0, 0, 1'b1, 1000);
        send(0, 0,    1'b0, 0, 1'b1, 0);
        send(0, 0,    1'b0, 0, 1'b1, 750);
        drain();

        // Channel isolation.
        do_reset();
        for (int i = 0; i < 9; i++) send(t3_ch[i], t3_x[i], 1'b0, 0, 1'b1, t3_exp[i]);
        drain();

        // Overrun: extra trig three cycles after accept.
        check("ovr_before", longint'(overrun), 0);
        send(0, 1234, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        check("ovr_not_yet", longint'(overrun), 0);
        @(negedge clk);
        sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        check("ovr_set", longint'(overrun), 1);
        send(1, -777, 1'b1, 4, 1'b0, 0);
        drain();
        check("ovr_sticky", longint'(overrun), 1);

        // Coefficient clamp with maximum step size.
        do_reset();
        sat_seen = 1'b0;
        for (int i = 0; i < 50; i++)
            send(0, (i % 2) ? -(longint'(1) <<< 22) : (longint'(1) <<< 22), 1'b1, 0, 1'b0, 0);
        drain();
        check("clamp_reached", longint'(sat_seen), 1);

        // Randomised traffic over all channels.
        for (int i = 0; i < 40; i++) begin
            rx = DATA_W'($urandom);
            send(int'($urandom_range(NCH - 1, 0)), longint'($signed(rx)),
                 1'($urandom_range(1, 0)), int'($urandom_range(40, 0)), 1'b0, 0);
        end
        drain();

        // Reset during MUL_R2S of a ch2 sample.
        do_reset();
        send(2, 3000, 1'b1, 12, 1'b0, 0);
        send(2, -500, 1'b1, 12, 1'b0, 0);
        send(2, 5000, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check("no_done_after_abort", longint'(filter_done), 0);
            @(negedge clk);
        end
        send(2, 1000, 1'b0, 0, 1'b1, 1000);
        send(2, 0,    1'b0, 0, 1'b1, 0);
        send(2, 0,    1'b0, 0, 1'b1, 750);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/filtr_anc_mc.md
Name: filtr_anc_mc

Overview:
Time-multiplexed, multi-channel adaptive notch filter. This is the parametrised successor of the single-channel adaptive filter in the audio path. It serves NCH independent channels, each with its own lattice state and adaptive coefficient, through one shared registered multiplier. It adds run-time step size, adaptation freeze, coefficient clamping, output saturation and overrun reporting.

Parameters:
DATA_W, 24, sample width (signed integer)
COEF_W, 35, coefficient width, format Q2.(COEF_W-2): value = int / 2^(COEF_W-2)
NCH, 4, number of channels (1..16)
CH_W, 2, channel index width, ceil(log2(NCH)), minimum 1
R, 2^(COEF_W-3), pole radius r (default 0.5)
R2, 2^(COEF_W-4), r^2 (default 0.25)
A_INIT, 0, reset value of every channel coefficient a
A_MAX, 2^(COEF_W-2)*15/8, clamp magnitude for a (1.875)

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-low reset
data_in  in  DATA_W  input sample x, sampled on accept
ch_in  in  CH_W  channel of data_in
sample_trig  in  1  request; accepted only when busy=0
adapt_en  in  1  1 = update a; 0 = a frozen (sampled on accept)
mu_shift  in  6  step size 2^-mu_shift (sampled on accept)
busy  out  1  high from cycle after accept through done cycle
filter_done  out  1  one-cycle pulse, result valid
data_out  out  DATA_W  notch output e, saturated
ch_out  out  CH_W  channel of data_out
coef_out  out  COEF_W  updated a of ch_out
overrun  out  1  sticky: sample_trig seen while busy

Behaviour:
- Reset (reset=0 at edge):
  - state=IDLE; busy, filter_done, overrun = 0.
  - data_out = 0, ch_out = 0, coef_out = A_INIT.
  - For every channel: s1 = s2 = 0, a = A_INIT.
  - Reset mid-operation aborts the sample: no filter_done, no channel state written.
- Per-channel state: s1, s2 (DATA_W+2 bits, signed, saturating) and a (COEF_W).
- Recursion for channel c with input x:
  - as1 = (a*s1)>>>(COEF_W-2)
  - s = sat(x - ((R*as1)>>>(COEF_W-2)) - ((R2*s2)>>>(COEF_W-2)))
  - e = s + as1 + s2
  - data_out = sat_DATA_W(e)
  - When adapt_en=1: a_new = clamp(a - ((e*s1)>>>mu_shift), -A_MAX, +A_MAX), computed at full product width before clamp, never wrapping. Otherwise a_new = a.
  - Channel update: s2 <= s1; s1 <= s; a <= a_new.
- Arithmetic rules:
  - >>> is arithmetic shift (floor).
  - Intermediate sums carry enough guard bits that no wrap occurs before saturation.
- FSM:
  - States: IDLE -> MUL_AS -> MUL_RAS -> MUL_R2S -> SUM -> MUL_UPD -> WRITE -> IDLE.
  - One multiplication issued per MUL_* state; the multiplier has 1-cycle registered latency.
- Accept and latency:
  - Accept = IDLE and sample_trig=1 at edge k. data_in, ch_in, adapt_en and mu_shift are latched at k.
  - filter_done=1 in exactly cycle k+6 (WRITE). Channel state commits at the end of WRITE.
  - data_out, ch_out and coef_out update in WRITE and hold until the next WRITE or reset.
- Back-to-back: sample_trig high in the WRITE cycle is ignored (busy=1). The earliest next accept is the cycle after WRITE, so minimum spacing is 7 cycles.
- Trig while busy: ignored, no state change, overrun <= 1. overrun clears only on reset.
- ch_in >= NCH: sample accepted, processed with zeroed state, nothing written back. filter_done fires with data_out = sat(x) and coef_out = A_INIT.
- Channels never interact; an untouched channel's state is bit-identical across other channels' samples.

Test Plan:
1. Reset check: assert reset=0 for 2 cycles, release -> busy=0, filter_done=0, overrun=0, data_out=0, coef_out=A_INIT. Read back each channel via a zero sample with adapt_en=0 -> data_out=0.
2. Impulse, defaults, adapt_en=0, ch0: x = 1000, 0, 0 spaced 7 cycles apart.
   - data_out = 1000, 0, 750 (s = -250, e = -250 + 1000).
   - filter_done exactly 6 cycles after each accept; coef_out = 0 throughout.
3. Channel isolation: impulse 1000 on ch1 interleaved with zeros on ch0 and ch2 -> ch1 outputs 1000, 0, 750; ch0 and ch2 outputs stay 0.
4. Overrun: accept at k, pulse sample_trig at k+3 -> no extra filter_done, overrun=1 from k+4, and it stays 1 after a following clean sample.
5. Clamp: adapt_en=1, mu_shift=0, ch0 alternating +/-2^22 for 50 samples -> coef_out magnitude never exceeds A_MAX, equals +/-A_MAX when saturated, and never changes sign by wrap.
6. Reset mid-operation: reset=0 during MUL_R2S of a ch2 sample -> no filter_done. The next ch2 impulse 1000 gives 1000, 0, 750 (state reinitialised).
